// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, per-opcode execute T3-T7, HALTED stop state.
// Optional mul/div/mfhi/mflo support is enabled by defining CU_MULDIV_EN.
module control_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] opcode,
    input  logic       CON_FF,
    output logic       PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout,
    output logic       PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin,
    output logic       GRA, GRB, GRC, Rin, Rout, BAout,
    output logic       IncPC, Read, Write,
    output logic [4:0] alu_op,
    output logic       Run,
    output logic [3:0] Present_state
);
    typedef enum logic [3:0] {
        S_RESET = 4'b0000, S_T0 = 4'b0001, S_T1 = 4'b0010, S_T2 = 4'b0011,
        S_T3 = 4'b0100, S_T4 = 4'b0101, S_T5 = 4'b0110, S_T6 = 4'b0111,
        S_T7 = 4'b1000, S_HALTED = 4'b1111
    } state_t;

    localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR = 5'b01010, OP_ADDI = 5'b01011, OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI = 5'b01101, OP_BR = 5'b10010, OP_JR = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t state_q, state_d;

    logic is_rr, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_halt;
    logic is_md, is_mfhi, is_mflo;

    assign is_rr   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_OR);
    assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_jr   = (opcode == OP_JR);
    assign is_halt = (opcode == OP_HALT);
`ifdef CU_MULDIV_EN
    assign is_md   = (opcode == 5'b01110) || (opcode == 5'b01111);
    assign is_mfhi = (opcode == 5'b10111);
    assign is_mflo = (opcode == 5'b11000);
`else
    assign is_md   = 1'b0;
    assign is_mfhi = 1'b0;
    assign is_mflo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr) state_q <= S_RESET;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET:  state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     state_d = S_T2;
            S_T2:     state_d = S_T3;
            S_T3: begin
                if (is_halt) state_d = S_HALTED;
                else if (is_rr || is_imm || is_ldi || is_ld || is_st || is_br || is_md) state_d = S_T4;
                else state_d = S_T0;
            end
            S_T4:     state_d = S_T5;
            S_T5:     state_d = (is_ld || is_st || is_br || is_md) ? S_T6 : S_T0;
            S_T6:     state_d = (is_ld || is_st) ? S_T7 : S_T0;
            S_T7:     state_d = S_T0;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RESET;
        endcase
    end

    assign Present_state = state_q;

    // Control word decode; anything not driven for a step stays 0.
    always_comb begin
        {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin} = '0;
        {GRA, GRB, GRC, Rin, Rout, BAout, IncPC, Read, Write} = '0;
        alu_op = 5'b00000;
        Run    = 1'b1;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
            S_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_rr || is_imm) begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                if (is_ldi || is_ld || is_st) begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                if (is_br) begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                if (is_jr) begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                if (is_md) begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                if (is_mfhi) begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                if (is_mflo) begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            end
            S_T4: begin
                if (is_rr) begin GRC = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
                if (is_imm) begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
                if (is_ldi || is_ld || is_st) begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = OP_ADD; end
                if (is_br) begin PCout = 1'b1; Yin = 1'b1; end
                if (is_md) begin
                    GRB = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; alu_op = opcode;
                end
            end
            S_T5: begin
                if (is_rr || is_imm || is_ldi) begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                if (is_ld || is_st) begin ZLowout = 1'b1; MARin = 1'b1; end
                if (is_br) begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = OP_ADD; end
                if (is_md) begin ZLowout = 1'b1; LOin = 1'b1; end
            end
            S_T6: begin
                if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
                if (is_st) begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                if (is_br) begin ZLowout = 1'b1; PCin = CON_FF; end
                if (is_md) begin ZHighout = 1'b1; HIin = 1'b1; end
            end
            S_T7: begin
                if (is_ld) begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                if (is_st) Write = 1'b1;
            end
            S_HALTED: Run = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: per-state control word, alu_op and state checks.
module tb_control_sequencer;
    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] opcode;
    logic       CON_FF;
    logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout;
    logic PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin;
    logic GRA, GRB, GRC, Rin, Rout, BAout, IncPC, Read, Write;
    logic [4:0] alu_op;
    logic Run;
    logic [3:0] Present_state;
    logic [26:0] ctrl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode), .CON_FF(CON_FF),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .CONin(CONin),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .alu_op(alu_op), .Run(Run), .Present_state(Present_state)
    );

    assign ctrl = {Run, PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout,
                   PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin,
                   GRA, GRB, GRC, Rin, Rout, BAout, IncPC, Read, Write};

    localparam logic [26:0] M_WRITE = 27'd1 << 0,  M_READ = 27'd1 << 1,  M_INCPC = 27'd1 << 2;
    localparam logic [26:0] M_BAOUT = 27'd1 << 3,  M_ROUT = 27'd1 << 4,  M_RIN = 27'd1 << 5;
    localparam logic [26:0] M_GRC = 27'd1 << 6,    M_GRB = 27'd1 << 7,   M_GRA = 27'd1 << 8;
    localparam logic [26:0] M_CONIN = 27'd1 << 9,  M_ZLOWIN = 27'd1 << 13, M_YIN = 27'd1 << 14;
    localparam logic [26:0] M_MDRIN = 27'd1 << 15, M_MARIN = 27'd1 << 16, M_IRIN = 27'd1 << 17;
    localparam logic [26:0] M_PCIN = 27'd1 << 18,  M_COUT = 27'd1 << 19,  M_MDROUT = 27'd1 << 22;
    localparam logic [26:0] M_ZLOWOUT = 27'd1 << 24, M_PCOUT = 27'd1 << 25, M_RUN = 27'd1 << 26;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Checks the current state at a negedge, then advances one cycle.
    task automatic step(input string tag, input logic [3:0] st, input logic [26:0] c, input logic [4:0] alu);
        check({tag, "_state"}, {28'd0, Present_state}, {28'd0, st});
        check({tag, "_ctrl"}, {5'd0, ctrl}, {5'd0, c | M_RUN});
        check({tag, "_alu"}, {27'd0, alu_op}, {27'd0, alu});
        @(negedge clk);
    endtask

    task automatic fetch(input string tag);
        step({tag, "_T0"}, 4'd1, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'd0);
        step({tag, "_T1"}, 4'd2, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0);
        step({tag, "_T2"}, 4'd3, M_MDROUT | M_IRIN, 5'd0);
    endtask

    initial begin
        clr = 1'b0; opcode = 5'b00000; CON_FF = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_state", {28'd0, Present_state}, 32'd0);
        check("rst_ctrl", {5'd0, ctrl}, {5'd0, M_RUN});
        check("rst_alu", {27'd0, alu_op}, 32'd0);
        clr = 1'b1;
        @(negedge clk);

        opcode = 5'b00011;
        fetch("add");
        step("add_T3", 4'd4, M_GRB | M_ROUT | M_YIN, 5'd0);
        step("add_T4", 4'd5, M_GRC | M_ROUT | M_ZLOWIN, 5'b00011);
        step("add_T5", 4'd6, M_ZLOWOUT | M_GRA | M_RIN, 5'd0);

        opcode = 5'b01100;
        fetch("andi");
        step("andi_T3", 4'd4, M_GRB | M_ROUT | M_YIN, 5'd0);
        step("andi_T4", 4'd5, M_COUT | M_ZLOWIN, 5'b01100);
        step("andi_T5", 4'd6, M_ZLOWOUT | M_GRA | M_RIN, 5'd0);

        for (int k = 0; k < 2; k++) begin
            opcode = 5'b10010; CON_FF = (k == 0);
            fetch("br");
            step("br_T3", 4'd4, M_GRA | M_ROUT | M_CONIN, 5'd0);
            step("br_T4", 4'd5, M_PCOUT | M_YIN, 5'd0);
            step("br_T5", 4'd6, M_COUT | M_ZLOWIN, 5'b00011);
            step(k == 0 ? "br_taken_T6" : "br_nottaken_T6", 4'd7,
                 M_ZLOWOUT | (k == 0 ? M_PCIN : 27'd0), 5'd0);
        end
        CON_FF = 1'b0;

        opcode = 5'b00010;
        fetch("st");
        step("st_T3", 4'd4, M_GRB | M_BAOUT | M_YIN, 5'd0);
        step("st_T4", 4'd5, M_COUT | M_ZLOWIN, 5'b00011);
        step("st_T5", 4'd6, M_ZLOWOUT | M_MARIN, 5'd0);
        step("st_T6", 4'd7, M_GRA | M_ROUT | M_MDRIN, 5'd0);
        step("st_T7", 4'd8, M_WRITE, 5'd0);

        opcode = 5'b00000;
        fetch("ld");
        step("ld_T3", 4'd4, M_GRB | M_BAOUT | M_YIN, 5'd0);
        step("ld_T4", 4'd5, M_COUT | M_ZLOWIN, 5'b00011);
        step("ld_T5", 4'd6, M_ZLOWOUT | M_MARIN, 5'd0);
        step("ld_T6", 4'd7, M_READ | M_MDRIN, 5'd0);
        step("ld_T7", 4'd8, M_MDROUT | M_GRA | M_RIN, 5'd0);

        opcode = 5'b10011;
        fetch("jr");
        step("jr_T3", 4'd4, M_GRA | M_ROUT | M_PCIN, 5'd0);

        opcode = 5'b11001;
        fetch("nop");
        step("nop_T3", 4'd4, 27'd0, 5'd0);

        opcode = 5'b01110;
        fetch("mul_off");
        step("mul_off_T3", 4'd4, 27'd0, 5'd0);

        // Abort a load in T6: no Rin may follow.
        opcode = 5'b00000;
        fetch("ldab");
        step("ldab_T3", 4'd4, M_GRB | M_BAOUT | M_YIN, 5'd0);
        step("ldab_T4", 4'd5, M_COUT | M_ZLOWIN, 5'b00011);
        step("ldab_T5", 4'd6, M_ZLOWOUT | M_MARIN, 5'd0);
        check("ldab_T6_state", {28'd0, Present_state}, 32'd7);
        clr = 1'b0;
        @(negedge clk);
        step("ldab_rst", 4'd0, 27'd0, 5'd0);
        clr = 1'b1;
        @(negedge clk);

        opcode = 5'b11010;
        fetch("halt");
        step("halt_T3", 4'd4, 27'd0, 5'd0);
        for (int k = 0; k < 10; k++) begin
            check("halted_state", {28'd0, Present_state}, 32'd15);
            check("halted_ctrl", {5'd0, ctrl}, 32'd0);
            @(negedge clk);
        end
        clr = 1'b0;
        @(negedge clk);
        check("unhalt_state", {28'd0, Present_state}, 32'd0);
        check("unhalt_ctrl", {5'd0, ctrl}, {5'd0, M_RUN});
        clr = 1'b1;
        @(negedge clk);
        check("unhalt_T0", {28'd0, Present_state}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
